pc_sequencer: RTL
=================

# pc_sequencer

Fetch-side controller that owns the program counter and sequences instruction fetch. It issues one request at a time to instruction memory over a req/ack handshake and advances the PC sequentially or to a redirect target (jump, then branch). It buffers redirects that arrive while a fetch is outstanding, and handles stall and halt. It sits between the control/branch unit and instruction memory, replacing the free-running PC register.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- AW, 32, address/PC width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  inhibit issue of a new fetch
- halt  in  1  stop sequencing after the current fetch completes
- branch_taken  in  1  branch redirect request (single-cycle pulse)
- branch_target  in  AW  branch destination
- jump_en  in  1  jump redirect request (single-cycle pulse)
- jump_target  in  AW  jump destination
- imem_req  out  1  fetch request
- imem_addr  out  AW  fetch address, always equal to current_pc
- imem_ack  in  1  fetch complete (one-cycle pulse)
- current_pc  out  AW  architectural PC
- instr_valid  out  1  one-cycle pulse: fetch at current_pc completed
- align_err  out  1  one-cycle pulse: misaligned redirect target rejected
- halted  out  1  sequencer in HALT

## Operation
- States: IDLE, REQ, HALT.
- IDLE:
  - halt=1 → HALT.
  - stall=1 → stay in IDLE.
  - Otherwise → REQ.
- REQ: imem_req=1. Hold until imem_ack. On ack:
  - pc ← next_pc.
  - instr_valid=1 that cycle.
  - → HALT if halt was seen (live or latched), else → IDLE.
- HALT: imem_req=0, halted=1. Only rst exits.
- next_pc priority:
  1. Pending jump
  2. Live jump_en
  3. Pending branch
  4. Live branch_taken
  5. pc+4
- Addition is modulo 2^AW: 32'hFFFF_FFFC + 4 → 32'h0000_0000.
- Redirect buffer:
  - In IDLE, or in REQ without ack, a redirect is latched into a single pending slot (valid + target).
  - A later jump overwrites a pending branch. A later branch does not overwrite a pending jump.
  - The slot clears on the ack that consumes it.
- Alignment: a target with [1:0] ≠ 0 is not latched or used, and align_err pulses in the cycle after the request. If jump and branch arrive together and only the jump is misaligned, the branch is used.
- halt arriving in REQ is latched. Sequencing stops after that ack.
- stall never drops imem_req mid-handshake. It only blocks IDLE→REQ.

## Timing
- Reset values: current_pc=RESET_PC, imem_req=0, instr_valid=0, align_err=0, halted=0, pending slot empty, state IDLE.
- First imem_req=1 is in the first cycle after rst deasserts (IDLE→REQ takes one cycle), with imem_addr=RESET_PC.
- Fetch cadence: minimum 2 cycles per instruction (REQ with same-cycle ack, then IDLE).
- current_pc updates on the edge that samples imem_ack. The new value is visible the next cycle.
- Redirect and ack in the same cycle: the live redirect is applied directly; no pending entry is created.
- Redirect during IDLE with stall: held pending until the stall releases and the next ack.
- rst in REQ: the request is abandoned, and imem_req=0 the next cycle. A late imem_ack is ignored outside REQ.
- imem_ack outside REQ: ignored, no state change.

## Structure
- Shared package cpu_pkg:
  - state enum (IDLE, REQ, HALT)
  - PC_INC = 4
  - RESET_PC default
  - redirect-kind encoding (NONE, BRANCH, JUMP)
- One natural sub-module, redirect_buffer: the pending slot, priority/overwrite rule and alignment check. Its output is {valid, target, err}.
- The FSM and PC register stay in pc_sequencer.

## Test plan
- Reset then free run, ack same cycle as req:
  - imem_addr = 0, 4, 8, …
  - instr_valid every 2nd cycle
  - halted=0
- Jump 0x100 asserted mid-REQ, ack 3 cycles later: the PC after ack is 0x100, not pc+4. The pending slot is then empty.
- jump_en (0x200) and branch_taken (0x300) in the same ack cycle → pc=0x200. Then branch pending and jump 0x400 arrives before the ack → pc=0x400.
- Branch target 0x102 → align_err pulse once, and the PC advances to pc+4.
- PC at 0xFFFF_FFFC, ack → current_pc=0x0000_0000.
- halt asserted in REQ → one more instr_valid, then halted=1 and imem_req=0 forever. Then rst → current_pc=RESET_PC and req resumes one cycle after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants for the PC sequencer.
package cpu_pkg;

    localparam int          AW_DEF       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_INC       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HALT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_JUMP   = 2'd2
    } redir_kind_e;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer and imem.
interface pc_sequencer_if #(
    parameter int AW = cpu_pkg::AW_DEF
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;

    modport master (output imem_req, output imem_addr, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_sequencer_redirect_buffer.sv
// Single-entry redirect slot: alignment filter, jump-over-branch overwrite,
// and resolution of the redirect to apply on the consuming ack.
module redirect_buffer
    import cpu_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_i,
    input  logic          clr_i,
    input  logic          chk_i,
    input  logic          jump_en_i,
    input  logic [AW-1:0] jump_target_i,
    input  logic          branch_taken_i,
    input  logic [AW-1:0] branch_target_i,
    output logic          rd_valid_o,
    output logic [AW-1:0] rd_target_o,
    output logic          err_o
);

    redir_kind_e   kind_q, kind_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic          err_q, err_d;
    logic          jv, bv;

    assign jv = jump_en_i && word_aligned(jump_target_i[1:0]);
    assign bv = branch_taken_i && word_aligned(branch_target_i[1:0]);

    // Buffered jump outranks a live one; live jump outranks a buffered branch.
    always_comb begin
        rd_valid_o  = 1'b1;
        rd_target_o = tgt_q;
        if (kind_q == RD_JUMP) begin
            rd_target_o = tgt_q;
        end else if (jv) begin
            rd_target_o = jump_target_i;
        end else if (kind_q == RD_BRANCH) begin
            rd_target_o = tgt_q;
        end else if (bv) begin
            rd_target_o = branch_target_i;
        end else begin
            rd_valid_o  = 1'b0;
        end
    end

    always_comb begin
        kind_d = kind_q;
        tgt_d  = tgt_q;
        err_d  = chk_i && ((jump_en_i && !jv) || (branch_taken_i && !bv));
        if (clr_i) begin
            kind_d = RD_NONE;
        end else if (cap_i) begin
            if (jv) begin
                kind_d = RD_JUMP;
                tgt_d  = jump_target_i;
            end else if (bv && kind_q != RD_JUMP) begin
                kind_d = RD_BRANCH;
                tgt_d  = branch_target_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q <= RD_NONE;
            tgt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            kind_q <= kind_d;
            tgt_q  <= tgt_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: one outstanding imem fetch at a time, sequential or
// redirected advance, stall gating of new issues, and terminal halt.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int          AW       = AW_DEF,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_sequencer_if.master        imem,
    input  logic                  stall_i,
    input  logic                  halt_i,
    input  logic                  branch_taken_i,
    input  logic [AW-1:0]         branch_target_i,
    input  logic                  jump_en_i,
    input  logic [AW-1:0]         jump_target_i,
    output logic [AW-1:0]         current_pc_o,
    output logic                  instr_valid_o,
    output logic                  align_err_o,
    output logic                  halted_o
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          halt_pend_q, halt_pend_d;
    logic          cap, fire;
    logic          rd_valid;
    logic [AW-1:0] rd_target;

    assign fire = (state_q == REQ) && imem.imem_ack;

    redirect_buffer #(.AW(AW)) u_rdbuf (
        .clk             (clk),
        .rst             (rst),
        .cap_i           (cap),
        .clr_i           (fire),
        .chk_i           (state_q != HALT),
        .jump_en_i       (jump_en_i),
        .jump_target_i   (jump_target_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .rd_valid_o      (rd_valid),
        .rd_target_o     (rd_target),
        .err_o           (align_err_o)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        halt_pend_d = halt_pend_q;
        cap         = 1'b0;
        unique case (state_q)
            IDLE: begin
                cap = 1'b1;
                if (halt_i)        state_d = HALT;
                else if (!stall_i) state_d = REQ;
            end
            REQ: begin
                if (imem.imem_ack) begin
                    pc_d        = rd_valid ? rd_target : pc_q + AW'(PC_INC);
                    state_d     = (halt_i || halt_pend_q) ? HALT : IDLE;
                    halt_pend_d = 1'b0;
                end else begin
                    // Redirects and halt seen mid-handshake wait for the ack.
                    cap         = 1'b1;
                    halt_pend_d = halt_pend_q | halt_i;
                end
            end
            HALT: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = pc_q;
    assign current_pc_o   = pc_q;
    assign instr_valid_o  = fire;
    assign halted_o       = (state_q == HALT);

endmodule
